// File: rtl/pipe_pkg.sv
// Shared constants and state encodings for the IF/ID stall controller.
// Optional build macro used by pipeline_stall_ctrl: STALL_STATS_EN.
package pipe_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with hold and flush; hold takes priority over flush.
module ifid_reg
    import pipe_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_hold,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr,
    output logic            o_valid
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc    <= '0;
            r_instr <= XLEN'(NOP_INSTR);
            r_valid <= 1'b0;
        end else if (i_hold) begin
            r_pc    <= r_pc;
            r_instr <= r_instr;
            r_valid <= r_valid;
        end else if (i_flush) begin
            r_pc    <= '0;
            r_instr <= XLEN'(NOP_INSTR);
            r_valid <= 1'b0;
        end else begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller owning the IF/ID register: turns hazard, branch and dmem-busy into pipeline controls.
// Define STALL_STATS_EN to add saturating load-use / flush / memory-wait cycle counters.
module pipeline_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int XLEN         = DEFAULT_XLEN,
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W        = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            hazard_i,
    input  logic            branch_i,
    input  logic            dmem_busy_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [XLEN-1:0] if_instr_i,
    output logic            pc_write_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_instr_o,
    output logic            ifid_valid_o,
    output logic            idex_bubble_o,
    output logic            pipe_hold_o,
    output logic            timeout_o,
    output logic [1:0]      state_o
`ifdef STALL_STATS_EN
    ,
    output logic [XLEN-1:0] stat_loaduse_o,
    output logic [XLEN-1:0] stat_flush_o,
    output logic [XLEN-1:0] stat_memwait_o
`endif
);

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0] w_waitCntNext;
    logic             r_timeout;
    logic             w_active;
    logic             w_memStall;
    logic             w_loadUse;
    logic             w_flush;

    // A MEM_WAIT cycle with busy low already follows the RUN priority rules.
    assign w_active   = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);
    assign w_memStall = w_active && dmem_busy_i;
    assign w_loadUse  = w_active && !dmem_busy_i && hazard_i;
    assign w_flush    = w_active && !dmem_busy_i && !hazard_i && branch_i;

    assign pc_write_o    = w_active && !dmem_busy_i && !hazard_i;
    assign idex_bubble_o = !w_active || w_loadUse;
    assign pipe_hold_o   = w_memStall;
    assign timeout_o     = r_timeout;
    assign state_o       = r_state;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) w_stateNext = ST_RUN;
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (dmem_busy_i)   w_stateNext = ST_MEM_WAIT;
                else if (!start_i) w_stateNext = ST_IDLE;
                else               w_stateNext = ST_RUN;
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        w_waitCntNext = '0;
        if (r_state == ST_RUN && dmem_busy_i) begin
            w_waitCntNext = CNT_W'(1);
        end else if (r_state == ST_MEM_WAIT && dmem_busy_i) begin
            w_waitCntNext = (r_waitCnt == {CNT_W{1'b1}}) ? r_waitCnt : r_waitCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_waitCnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_waitCntNext;
            if (w_memStall && (w_waitCntNext >= CNT_W'(MAX_MEM_WAIT))) begin
                r_timeout <= 1'b1;
            end
        end
    end

    ifid_reg #(
        .XLEN(XLEN)
    ) u_ifid (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_hold  (w_memStall || w_loadUse),
        .i_flush (!w_active || w_flush),
        .i_pc    (if_pc_i),
        .i_instr (if_instr_i),
        .o_pc    (ifid_pc_o),
        .o_instr (ifid_instr_o),
        .o_valid (ifid_valid_o)
    );

`ifdef STALL_STATS_EN
    logic [XLEN-1:0] r_statLoadUse;
    logic [XLEN-1:0] r_statFlush;
    logic [XLEN-1:0] r_statMemWait;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_statLoadUse <= '0;
            r_statFlush   <= '0;
            r_statMemWait <= '0;
        end else begin
            if (w_loadUse && (r_statLoadUse != {XLEN{1'b1}}))
                r_statLoadUse <= r_statLoadUse + XLEN'(1);
            if (w_flush && (r_statFlush != {XLEN{1'b1}}))
                r_statFlush <= r_statFlush + XLEN'(1);
            if ((r_state == ST_MEM_WAIT) && (r_statMemWait != {XLEN{1'b1}}))
                r_statMemWait <= r_statMemWait + XLEN'(1);
        end
    end

    assign stat_loaduse_o = r_statLoadUse;
    assign stat_flush_o   = r_statFlush;
    assign stat_memwait_o = r_statMemWait;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed cycles push hand-computed expectations, a negedge monitor checks them.
module tb_pipeline_stall_ctrl;
    import pipe_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        hazard_i = 1'b0;
    logic        branch_i = 1'b0;
    logic        dmem_busy_i = 1'b0;
    logic [31:0] if_pc_i = '0;
    logic [31:0] if_instr_i = '0;
    logic        pc_write_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic        idex_bubble_o;
    logic        pipe_hold_o;
    logic        timeout_o;
    logic [1:0]  state_o;
`ifdef STALL_STATS_EN
    logic [31:0] stat_loaduse_o;
    logic [31:0] stat_flush_o;
    logic [31:0] stat_memwait_o;
`endif

    typedef struct packed {
        logic [15:0] step;
        logic [1:0]  state;
        logic        pcWrite;
        logic        bubble;
        logic        hold;
        logic        valid;
        logic [31:0] pc;
        logic        tmo;
    } exp_t;

    exp_t scoreboard[$];
    int   checks = 0;
    int   passes = 0;
    int   stepNum = 0;

    always #5 clk_i = ~clk_i;

    pipeline_stall_ctrl #(
        .XLEN(32),
        .MAX_MEM_WAIT(15),
        .CNT_W(4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .hazard_i      (hazard_i),
        .branch_i      (branch_i),
        .dmem_busy_i   (dmem_busy_i),
        .if_pc_i       (if_pc_i),
        .if_instr_i    (if_instr_i),
        .pc_write_o    (pc_write_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_valid_o  (ifid_valid_o),
        .idex_bubble_o (idex_bubble_o),
        .pipe_hold_o   (pipe_hold_o),
        .timeout_o     (timeout_o),
        .state_o       (state_o)
`ifdef STALL_STATS_EN
        ,
        .stat_loaduse_o(stat_loaduse_o),
        .stat_flush_o  (stat_flush_o),
        .stat_memwait_o(stat_memwait_o)
`endif
    );

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return 32'h00000033 | (pc << 8);
    endfunction

    task automatic cmp(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL step %0d %s: got %h expected %h", step, nm, act, exp);
        else
            passes++;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [31:0] expInstr;
        expInstr = e.valid ? instrOf(e.pc) : NOP_INSTR;
        cmp("state", int'(e.step), 32'(state_o), 32'(e.state));
        cmp("pc_write", int'(e.step), 32'(pc_write_o), 32'(e.pcWrite));
        cmp("idex_bubble", int'(e.step), 32'(idex_bubble_o), 32'(e.bubble));
        cmp("pipe_hold", int'(e.step), 32'(pipe_hold_o), 32'(e.hold));
        cmp("ifid_valid", int'(e.step), 32'(ifid_valid_o), 32'(e.valid));
        cmp("ifid_instr", int'(e.step), ifid_instr_o, expInstr);
        cmp("timeout", int'(e.step), 32'(timeout_o), 32'(e.tmo));
        if (e.valid)
            cmp("ifid_pc", int'(e.step), ifid_pc_o, e.pc);
    endtask

    task automatic applyStimulus(input logic rst, input logic st, input logic hz, input logic br,
                                 input logic bz, input logic [31:0] pc, input logic [1:0] expState,
                                 input logic pw, input logic bub, input logic hold, input logic valid,
                                 input logic [31:0] ifPc, input logic tmo);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i       = rst;
        start_i     = st;
        hazard_i    = hz;
        branch_i    = br;
        dmem_busy_i = bz;
        if_pc_i     = pc;
        if_instr_i  = instrOf(pc);
        stepNum++;
        e.step    = 16'(stepNum);
        e.state   = expState;
        e.pcWrite = pw;
        e.bubble  = bub;
        e.hold    = hold;
        e.valid   = valid;
        e.pc      = ifPc;
        e.tmo     = tmo;
        scoreboard.push_back(e);
    endtask

    // Monitor: outputs are settled at the falling edge, one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        $display("[TB] starting pipeline_stall_ctrl bench");
        // rst st hz br bz  pc  | state pw bub hold valid ifPc tmo
        applyStimulus(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0,  0, 0);
        applyStimulus(1, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0,  0, 0);
        applyStimulus(1, 1, 0, 0, 0,  0, 1, 1, 0, 0, 0,  0, 0);
        applyStimulus(1, 1, 0, 0, 0,  4, 1, 1, 0, 0, 1,  0, 0);
        applyStimulus(1, 1, 0, 0, 0,  8, 1, 1, 0, 0, 1,  4, 0);
        // single load-use stall with PC 8 in IF/ID
        applyStimulus(1, 1, 1, 0, 0, 12, 1, 0, 1, 0, 1,  8, 0);
        applyStimulus(1, 1, 0, 0, 0, 12, 1, 1, 0, 0, 1,  8, 0);
        // hazard masks branch, then branch alone flushes
        applyStimulus(1, 1, 1, 1, 0, 16, 1, 0, 1, 0, 1, 12, 0);
        applyStimulus(1, 1, 0, 1, 0, 16, 1, 1, 0, 0, 1, 12, 0);
        applyStimulus(1, 1, 0, 0, 0, 20, 1, 1, 0, 0, 0,  0, 0);
        // five busy cycles; hazard and branch ignored while waiting
        applyStimulus(1, 1, 0, 0, 1, 24, 1, 0, 0, 1, 1, 20, 0);
        applyStimulus(1, 1, 0, 0, 1, 24, 2, 0, 0, 1, 1, 20, 0);
        applyStimulus(1, 1, 1, 0, 1, 24, 2, 0, 0, 1, 1, 20, 0);
        applyStimulus(1, 1, 0, 1, 1, 24, 2, 0, 0, 1, 1, 20, 0);
        applyStimulus(1, 1, 0, 0, 1, 24, 2, 0, 0, 1, 1, 20, 0);
        applyStimulus(1, 1, 0, 0, 0, 24, 2, 1, 0, 0, 1, 20, 0);
        applyStimulus(1, 1, 0, 0, 0, 28, 1, 1, 0, 0, 1, 24, 0);
        // twenty busy cycles: counter hits 15 at the end of busy cycle 15
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1, 1, 0, 0, 1, 32, (k == 1) ? 2'd1 : 2'd2, 0, 0, 1, 1, 28, (k >= 16));
        end
        applyStimulus(1, 1, 0, 0, 0, 32, 2, 1, 0, 0, 1, 28, 1);
        applyStimulus(1, 1, 0, 0, 0, 36, 1, 1, 0, 0, 1, 32, 1);
        // start low returns to IDLE, timeout stays sticky
        applyStimulus(1, 0, 0, 0, 0, 40, 1, 1, 0, 0, 1, 36, 1);
        applyStimulus(1, 0, 0, 0, 0, 44, 0, 0, 1, 0, 1, 40, 1);
        applyStimulus(1, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0,  0, 1);
        applyStimulus(1, 1, 0, 0, 1,  0, 1, 0, 0, 1, 0,  0, 1);
        // start low while busy must keep waiting
        applyStimulus(1, 0, 0, 0, 1,  0, 2, 0, 0, 1, 0,  0, 1);
        // asynchronous reset in MEM_WAIT, observed before the next rising edge
        applyStimulus(0, 1, 0, 0, 1,  0, 0, 0, 1, 0, 0,  0, 0);
        applyStimulus(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0,  0, 0);

        for (int w = 0; w < 5 && scoreboard.size() > 0; w++) @(negedge clk_i);
        #1;
        if (scoreboard.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain: got %0d pending expected 0", scoreboard.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Consumer side of the load-use hazard signal. Owns the IF/ID pipeline register and turns ID-stage hazard, ID-stage branch-taken and MEM-stage busy indications into PC write-enable, IF/ID hold/flush, ID/EX bubble insertion and back-end freeze.
Sits between the IF stage and the ID-stage decode and hazard logic in the 5-stage RISC-V core.

Parameters:
XLEN, 32, width of PC and instruction
MAX_MEM_WAIT, 15, max consecutive dmem_busy_i cycles before timeout_o is set
CNT_W, 4, width of the memory-wait counter; must satisfy 2^CNT_W > MAX_MEM_WAIT

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous active-low reset
start_i  in  1  level; core runs while high
hazard_i  in  1  load-use hazard from ID-stage detection
branch_i  in  1  branch/jump taken, resolved in ID
dmem_busy_i  in  1  data memory not ready in MEM
if_pc_i  in  XLEN  PC of the fetched instruction
if_instr_i  in  XLEN  fetched instruction
pc_write_o  out  1  PC register update enable
ifid_pc_o  out  XLEN  registered PC to ID
ifid_instr_o  out  XLEN  registered instruction to ID
ifid_valid_o  out  1  IF/ID slot holds a real instruction
idex_bubble_o  out  1  zero ID/EX control fields this cycle
pipe_hold_o  out  1  freeze ID/EX, EX/MEM, MEM/WB registers
timeout_o  out  1  sticky: memory wait exceeded MAX_MEM_WAIT
state_o  out  2  current FSM state

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; ifid_pc_o=0; ifid_instr_o=NOP (32'h00000013); ifid_valid_o=0; wait counter=0; timeout_o=0.
- All control outputs are combinational from state and inputs. The IF/ID register and FSM update on posedge clk_i.
- States: IDLE=0, RUN=1, MEM_WAIT=2. Encoding 3 is illegal and returns to IDLE.
- IDLE: pc_write_o=0, idex_bubble_o=1, pipe_hold_o=0. IF/ID loads NOP with valid=0. Go to RUN when start_i=1.
- RUN priority, highest first:
  (a) dmem_busy_i=1: pc_write_o=0, IF/ID holds, pipe_hold_o=1, idex_bubble_o=0. Next state MEM_WAIT; counter=1.
  (b) hazard_i=1: pc_write_o=0, IF/ID holds, idex_bubble_o=1. branch_i is ignored this cycle because its operands are not yet valid.
  (c) branch_i=1: pc_write_o=1. IF/ID loads NOP with valid=0, discarding the wrong-path fetch.
  (d) otherwise: pc_write_o=1. IF/ID loads if_pc_i/if_instr_i with valid=1.
- MEM_WAIT: same outputs as (a). hazard_i and branch_i are ignored.
  - Counter increments while dmem_busy_i=1, saturating at 2^CNT_W-1.
  - When the counter reaches MAX_MEM_WAIT, timeout_o is set and stays set until reset.
  - When dmem_busy_i=0: return to RUN and clear the counter. The RUN priority rules apply in that same cycle.
- start_i low in RUN or MEM_WAIT: go to IDLE only when dmem_busy_i=0. An outstanding memory access is never abandoned.
- A single hazard_i pulse yields exactly one stall cycle and one bubble. The stalled instruction advances on the next cycle.
- Mid-operation reset: all state clears immediately. A pending flush or stall is lost.

Optional Feature:
STALL_STATS_EN
- Defined: adds three XLEN-wide saturating counters, exposed as output ports stat_loaduse_o, stat_flush_o and stat_memwait_o. They count cycles of case (b), case (c), and cycles spent in MEM_WAIT. Reset clears them; they do not count in IDLE.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package pipe_pkg: NOP_INSTR=32'h00000013, state encodings ST_IDLE/ST_RUN/ST_MEM_WAIT, XLEN default.
- One sub-module, ifid_reg: IF/ID register with hold and flush inputs. The FSM and priority logic stay in the top module.

Test Plan:
- Reset then start_i=1, no events, PCs 0,4,8 fed -> ifid_pc_o follows one cycle later, ifid_valid_o=1, pc_write_o=1 each cycle.
- hazard_i=1 for one cycle with IF/ID holding PC 8 -> pc_write_o=0, idex_bubble_o=1 that cycle; ifid_pc_o stays 8; next cycle advances to 12.
- hazard_i=1 and branch_i=1 together -> stall taken, no flush (ifid_valid_o stays 1); branch_i=1 alone next cycle -> ifid_instr_o=32'h00000013, ifid_valid_o=0.
- dmem_busy_i=1 for 5 cycles -> state_o=2, pipe_hold_o=1 and pc_write_o=0 for all 5 cycles; RUN on the 6th; timeout_o=0.
- dmem_busy_i held 20 cycles with MAX_MEM_WAIT=15 -> timeout_o rises on the 15th busy cycle and stays 1 after busy drops; clears only on rst_i low.
- rst_i low asynchronously mid-MEM_WAIT -> state_o=0, ifid_valid_o=0, timeout_o=0 before the next clock edge.
